// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative multiply/divide unit for the HI/LO group.
// Multiplies run radix-2 shift-add and divides run restoring division, each
// over magnitudes, with the sign fixed up in a final cycle.
// Optional feature macro: MULDIV_FAST_MUL_EN selects a single-cycle multiply.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no operation in flight
// ITER  | one multiplier bit / quotient bit per cycle, WIDTH cycles
// FIXUP | sign-correct the magnitudes and load hi_out/lo_out
// DONE  | result valid, HI/LO write pulses asserted for this cycle
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sign,
   input  logic             div,
   input  logic             flush,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic             w_hi,
   output logic             w_lo,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIXUP, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               div_op_q, div_op_d;
   logic               neg_quo_q, neg_quo_d;
   logic               neg_rem_q, neg_rem_d;
   logic               bzero_q, bzero_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic [WIDTH-1:0]   mag_a, mag_b;
   logic               neg_quo_in;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH+1:0]   div_diff;
   logic [WIDTH-1:0]   rem, quo;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_prod;
`endif

   // Operand magnitudes and the per-step arithmetic for both iterative paths
   always_comb begin
      mag_a      = (sign && a[WIDTH-1]) ? -a : a;
      mag_b      = (sign && b[WIDTH-1]) ? -b : b;
      neg_quo_in = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
      // Multiplier sits in acc low half and shifts out LSB-first.
      mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      // Shifted partial remainder can reach WIDTH+1 bits; one extra bit for the sign.
      div_diff   = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opb_q};
      rem        = acc_q[2*WIDTH-1:WIDTH];
      quo        = acc_q[WIDTH-1:0];
`ifdef MULDIV_FAST_MUL_EN
      fast_prod  = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif
   end

   // Next-state, datapath update and result load
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      cnt_d     = cnt_q;
      div_op_d  = div_op_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      bzero_d   = bzero_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_ITER;
               div_op_d  = div;
               neg_quo_d = neg_quo_in;
               neg_rem_d = sign & a[WIDTH-1];
               bzero_d   = (b == '0);
               cnt_d     = '0;
               opb_d     = div ? mag_b : mag_a;
               acc_d     = {{WIDTH{1'b0}}, (div ? mag_a : mag_b)};
`ifdef MULDIV_FAST_MUL_EN
               if (!div) begin
                  state_d      = S_DONE;
                  {hi_d, lo_d} = neg_quo_in ? -fast_prod : fast_prod;
               end
`endif
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
         end
         S_ITER: begin
            cnt_d = cnt_q + CW'(1);
            if (div_op_q) begin
               if (!div_diff[WIDTH+1])
                  acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               else
                  acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            if (cnt_q == CW'(WIDTH - 1))
               state_d = S_FIXUP;
         end
         S_FIXUP: begin
            state_d = S_DONE;
            if (!div_op_q) begin
               {hi_d, lo_d} = neg_quo_q ? -acc_q : acc_q;
            end else begin
               // Dividing by zero leaves |a| in the remainder, so the normal
               // remainder fix reproduces the raw dividend; only lo is forced.
               hi_d = neg_rem_q ? -rem : rem;
               lo_d = bzero_q ? '1 : (neg_quo_q ? -quo : quo);
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d = S_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         opb_q     <= '0;
         cnt_q     <= '0;
         div_op_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         bzero_q   <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         cnt_q     <= cnt_d;
         div_op_q  <= div_op_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         bzero_q   <= bzero_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   // Pipeline handshake outputs; stall drops in DONE so HI/LO write proceeds
   always_comb begin
      stall  = ((state_q == S_IDLE) && start && !flush) ||
               (state_q == S_ITER) || (state_q == S_FIXUP);
      busy   = (state_q != S_IDLE);
      done   = (state_q == S_DONE);
      w_hi   = done;
      w_lo   = done;
      hi_out = hi_q;
      lo_out = lo_q;
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: directed cases with literal results plus a
// long randomized run compared every cycle against an operation-level model.
module tb_muldiv_sequencer;

   localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int LAT_MUL = 1;
`else
   localparam int LAT_MUL = W + 2;
`endif
   localparam int LAT_DIV = W + 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1, start = 1'b0, sign = 1'b0, div = 1'b0, flush = 1'b0;
   logic [W-1:0]  a = '0, b = '0;
   logic          stall, busy, done, w_hi, w_lo;
   logic [W-1:0]  hi_out, lo_out;

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .sign(sign), .div(div), .flush(flush),
      .a(a), .b(b), .stall(stall), .busy(busy), .done(done),
      .w_hi(w_hi), .w_lo(w_lo), .hi_out(hi_out), .lo_out(lo_out)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Architectural result {hi, lo} from plain 64-bit arithmetic.
   function automatic logic [63:0] ref_result(input logic [31:0] ra, input logic [31:0] rb,
                                              input logic rs, input logic rd);
      longint      sa, sb, q, r;
      logic [63:0] qv, rv;
      sa = rs ? longint'($signed(ra)) : longint'(ra);
      sb = rs ? longint'($signed(rb)) : longint'(rb);
      if (!rd) return 64'(sa * sb);
      if (rb == 32'd0) return {ra, 32'hFFFF_FFFF};
      q  = sa / sb;
      r  = sa % sb;
      qv = 64'(q);
      rv = 64'(r);
      return {rv[31:0], qv[31:0]};
   endfunction

   // Operation-level model: age counts cycles since the issuing cycle.
   bit          m_valid  = 1'b0;
   bit          m_active = 1'b0;
   int          m_age    = 0;
   int          m_lat    = 0;
   logic [31:0] m_hi     = '0;
   logic [31:0] m_lo     = '0;
   logic [63:0] m_pend   = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_valid  <= 1'b1;
         m_active <= 1'b0;
         m_hi     <= '0;
         m_lo     <= '0;
      end else if (!m_valid) begin
         m_active <= 1'b0;
      end else if (flush) begin
         m_active <= 1'b0;
      end else if ((!m_active || m_age == m_lat) && start) begin
         m_pend   <= ref_result(a, b, sign, div);
         m_lat    <= div ? LAT_DIV : LAT_MUL;
         m_age    <= 1;
         m_active <= 1'b1;
         if (!div && LAT_MUL == 1) {m_hi, m_lo} <= ref_result(a, b, sign, div);
      end else if (m_active && m_age == m_lat) begin
         m_active <= 1'b0;
      end else if (m_active) begin
         m_age <= m_age + 1;
         if (m_age + 1 == m_lat) {m_hi, m_lo} <= m_pend;
      end
   end

   logic e_done, e_stall;
   always @(negedge clk) begin
      if (m_valid) begin
         e_done  = m_active && (m_age == m_lat);
         e_stall = (!m_active && start && !flush) || (m_active && m_age < m_lat);
         chk("model_stall", 64'(stall), 64'(e_stall));
         chk("model_busy",  64'(busy),  64'(m_active));
         chk("model_done",  64'(done),  64'(e_done));
         chk("model_w_hi",  64'(w_hi),  64'(e_done));
         chk("model_w_lo",  64'(w_lo),  64'(e_done));
         chk("model_hi",    64'(hi_out), 64'(m_hi));
         chk("model_lo",    64'(lo_out), 64'(m_lo));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string nm, input logic [31:0] ra, input logic [31:0] rb,
                         input logic rs, input logic rd, input logic [31:0] e_hi,
                         input logic [31:0] e_lo, input int e_lat);
      int n;
      a = ra; b = rb; sign = rs; div = rd; start = 1'b1;
      #1;
      chk({nm, "_stall0"}, 64'(stall), 64'(1));
      tick();
      start = 1'b0;
      n = 1;
      while (!done && n < 80) begin
         tick();
         n++;
      end
      chk({nm, "_latency"}, 64'(n), 64'(e_lat));
      chk({nm, "_hi"}, 64'(hi_out), 64'(e_hi));
      chk({nm, "_lo"}, 64'(lo_out), 64'(e_lo));
      chk({nm, "_wr"}, 64'({w_hi, w_lo}), 64'(2'b11));
      tick();
      chk({nm, "_pulse"}, 64'(done), 64'(0));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'd1;
         4: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n;
      // reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_outs", 64'({stall, busy, done, w_hi, w_lo}), 64'(0));
      chk("rst_hilo", {hi_out, lo_out}, 64'(0));

      run_op("mult_neg",  32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, LAT_MUL);
      run_op("divu",      32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 32'd14, LAT_DIV);
      run_op("div_neg",   32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT_DIV);
      run_op("div_ovf",   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 32'h8000_0000, LAT_DIV);
      run_op("divu_zero", 32'h1234, 32'd0, 1'b0, 1'b1, 32'h1234, 32'hFFFF_FFFF, LAT_DIV);

      // flush during cycle 10 of a divide, restart at cycle 12
      a = 32'd1000; b = 32'd3; sign = 1'b1; div = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      while (n < 10) begin tick(); n++; end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_busy", 64'({busy, done}), 64'(0));
      chk("flush_hilo", {hi_out, lo_out}, {32'h1234, 32'hFFFF_FFFF});
      tick();
      run_op("after_flush", 32'd1000, 32'd3, 1'b1, 1'b1, 32'd1, 32'd333, LAT_DIV);

      // back-to-back with start held through DONE, then stray starts in ITER
      a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; sign = 1'b0; div = 1'b0; start = 1'b1;
      tick();
      n = 1;
      while (!done && n < 80) begin tick(); n++; end
      chk("b2b_first_lat", 64'(n), 64'(LAT_MUL));
      tick();
      n = 1;
      while (!done && n < 80) begin
         start = (n == 5 || n == 17);
         a = start ? 32'd5 : 32'hFFFF_FFFF;
         tick();
         n++;
      end
      start = 1'b0;
      chk("b2b_second_lat", 64'(n), 64'(LAT_MUL));
      chk("b2b_hilo", {hi_out, lo_out}, {32'hFFFF_FFFE, 32'h0000_0001});
      tick();

      // reset in the middle of an operation
      a = 32'd50; b = 32'd7; sign = 1'b0; div = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      while (n < 20) begin tick(); n++; end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_outs", 64'({stall, busy, done, w_hi, w_lo}), 64'(0));
      chk("midrst_hilo", {hi_out, lo_out}, 64'(0));

      // randomized traffic, checked by the per-cycle model compare
      for (int i = 0; i < 6000; i++) begin
         start = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 79) == 0);
         rst   = ($urandom_range(0, 999) == 0);
         sign  = 1'($urandom_range(0, 1));
         div   = 1'($urandom_range(0, 1));
         a     = pick();
         b     = pick();
         tick();
      end
      start = 1'b0; flush = 1'b0; rst = 1'b0;
      repeat (40) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller and datapath for the MIPS HI/LO arithmetic group: `mult`, `multu`, `div` and `divu`. It sits in the EXE stage beside the ALU. It takes the `sign`/`div` operation flags and the two operands from the decoder. While an operation runs it holds the pipeline stalled. On completion it presents 64-bit results with one-cycle `w_hi`/`w_lo` write pulses toward the HI/LO register pair.

## Interface
- `WIDTH`, 32: operand width. HI and LO are each `WIDTH` bits. Iteration count equals `WIDTH`.
- `clk` input 1: single clock. All state changes on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: issue the operation presented this cycle. Sampled only in IDLE or DONE.
- `sign` input 1: 1 = signed (`mult`/`div`), 0 = unsigned.
- `div` input 1: 1 = divide, 0 = multiply.
- `flush` input 1: abort the in-flight operation (exception/eret). Has priority over `start`.
- `a` input WIDTH: rs operand (multiplicand / dividend).
- `b` input WIDTH: rt operand (multiplier / divisor).
- `stall` output 1: freeze IF–EXE while the operation is incomplete.
- `busy` output 1: state ≠ IDLE.
- `done` output 1: result valid this cycle (state DONE).
- `w_hi`, `w_lo` output 1: HI/LO write enables. Both equal `done`.
- `hi_out`, `lo_out` output WIDTH: remainder/quotient (div), or upper/lower product (mult). Registered.

## Operation
- States: IDLE, ITER, FIXUP, DONE. Registers: operand/accumulator (2·WIDTH), divisor/multiplicand magnitude, counter (log2 WIDTH + 1), op flags, sign flags.
- IDLE/DONE + `start` → ITER:
  - latch `sign`/`div`;
  - latch magnitudes |a| and |b| (two's-complement negate when `sign` and MSB set);
  - latch `neg_q` = sign & (a[MSB] ^ b[MSB]) and `neg_r` = sign & a[MSB];
  - clear counter.
- DONE without `start` → IDLE.
- ITER, multiply: radix-2 shift-add, one multiplier bit per cycle, 64-bit accumulator.
- ITER, divide: restoring division, one quotient bit per cycle. Shift remainder:quotient left, subtract the divisor, keep the result if non-negative and set the quotient bit.
- ITER → FIXUP when counter reaches WIDTH−1 (exactly WIDTH iterations).
- FIXUP → DONE. The `hi_out`/`lo_out` registers load on this edge:
  - mult: 64-bit product, negated if `neg_q`.
  - div: lo = quotient (negated if `neg_q`), hi = remainder (negated if `neg_r`).
  - div by zero (b == 0 latched): lo = all-ones, hi = a (raw). No sign fix.
  - 0x80000000 / −1 signed: lo = 0x80000000, hi = 0. This falls out of magnitude arithmetic.
- `flush` in any state → IDLE next edge. `done`/`w_hi`/`w_lo` never assert for the flushed operation. `hi_out`/`lo_out` keep their previous values.
- `start` in ITER/FIXUP is ignored. The decoder is stalled and cannot re-issue.
- `stall` = (IDLE & `start` & ~`flush`) | ITER | FIXUP. `stall` is low in DONE so the pipeline advances while HI/LO are written.

## Timing
- Reset: state IDLE, counter 0, `hi_out`=`lo_out`=0, `stall`=`busy`=`done`=`w_hi`=`w_lo`=0.
- Cycle 0 (`start` high in IDLE): `stall`=1 combinationally. ITER entered at the end of cycle 0.
- Cycles 1..WIDTH: ITER. Cycle WIDTH+1: FIXUP. Cycle WIDTH+2 (34 for WIDTH=32): DONE, `done`=`w_hi`=`w_lo`=1 for exactly one cycle.
- `stall` is high for cycles 0..WIDTH+1 (34 cycles for WIDTH=32).
- Back-to-back: `start` in the DONE cycle re-enters ITER. The next DONE follows 34 cycles later.
- `rst` mid-operation: same as reset. It also clears `hi_out`/`lo_out`.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - multiplies use a single-cycle full 2·WIDTH signed/unsigned product;
  - IDLE/DONE + `start` with `div`=0 → DONE directly, with `hi_out`/`lo_out` loaded on that edge;
  - `done` is in cycle 1 and `stall` is high only in cycle 0;
  - divides are unchanged.
- Not defined: multiplies use the iterative path, with the same latency as divides.

## Test plan
- Signed mult a=0xFFFFFFFD (−3), b=5 → cycle 34: hi=0xFFFFFFFF, lo=0xFFFFFFF1, `w_hi`=`w_lo`=1 for one cycle. `stall` is high for cycles 0–33. With `MULDIV_FAST_MUL_EN`: same values at cycle 1.
- divu a=100, b=7 → lo=14, hi=2. Signed div a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Signed div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. divu a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234.
- `flush` at cycle 10 of a div → `busy`=0 from cycle 11, no `done` pulse, `hi_out`/`lo_out` unchanged. A new `start` at cycle 12 completes normally 34 cycles later.
- `start` held in DONE with multu a=0xFFFFFFFF, b=0xFFFFFFFF → second `done` 34 cycles later with hi=0xFFFFFFFE, lo=0x00000001. `start` pulses during ITER are ignored.
- `rst` at cycle 20 → all outputs 0 on the next cycle, state IDLE.
